sa_adc_sequencer: RTL and testbench

Conversion scheduler and oversampling controller for the SA_ADC successive-approximation converter. It issues periodic start pulses to the converter and waits for each result, with a timeout. It averages 2^n results per output word and presents each averaged word on a ready/valid interface. It sits between the SA_ADC instance and downstream consumers in main, replacing free-running capture.

---
 rtl/sa_adc_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_sa_adc_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_adc_sequencer.sv
// Conversion scheduler and 2^n oversampling averager for the SA_ADC converter.
// Define SA_ADC_SEQ_ROUND_EN for round-half-up averaging instead of truncation.
module sa_adc_sequencer #(
    parameter int DATA_W       = 14,
    parameter int PERIOD_W     = 16,
    parameter int OSR_LOG2_MAX = 4,
    parameter int TIMEOUT      = 1023
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [2:0]          osr_log2_i,
    input  logic                clear_i,
    output logic                adc_start_o,
    input  logic [DATA_W-1:0]   adc_data_i,
    input  logic                adc_rdy_i,
    output logic [DATA_W-1:0]   res_data_o,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic                busy_o,
    output logic                overrun_o,
    output logic                timeout_o
);

    localparam int ACC_W = DATA_W + OSR_LOG2_MAX;
    localparam int CNT_W = OSR_LOG2_MAX + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    // The timeout counter starts one cycle after the start pulse, so the last
    // CONVERT cycle sees TIMEOUT-2 and the flag rises TIMEOUT cycles after START.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        START,
        CONVERT,
        DONE
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] pcnt;
    logic                tick_pending;
    logic [TO_W-1:0]     tcnt;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          osr_q;

    logic                tick;
    logic                start_go;
    logic [2:0]          osr_clamped;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    group_len;
    logic [ACC_W-1:0]    acc_sum;

`ifdef SA_ADC_SEQ_ROUND_EN
    function automatic logic [DATA_W-1:0] average(input logic [ACC_W-1:0] sum,
                                                  input logic [2:0] sh);
        logic [ACC_W:0] biased;
        logic [ACC_W:0] q;
        biased = {1'b0, sum};
        if (sh != 3'd0)
            biased = biased + ({{ACC_W{1'b0}}, 1'b1} << (sh - 3'd1));
        q = biased >> sh;
        if (q > {{(OSR_LOG2_MAX + 1){1'b0}}, {DATA_W{1'b1}}})
            return {DATA_W{1'b1}};
        return DATA_W'(q);
    endfunction
`else
    function automatic logic [DATA_W-1:0] average(input logic [ACC_W-1:0] sum,
                                                  input logic [2:0] sh);
        return DATA_W'(sum >> sh);
    endfunction
`endif

    assign tick        = enable_i && (pcnt == period_i);
    assign start_go    = (state == WAIT_TICK) && enable_i && tick_pending;
    assign osr_clamped = (osr_log2_i > 3'(OSR_LOG2_MAX)) ? 3'(OSR_LOG2_MAX) : osr_log2_i;
    assign cnt_inc     = cnt + 1'b1;
    assign group_len   = CNT_W'(1) << osr_q;
    assign acc_sum     = acc + ACC_W'(adc_data_i);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state        <= IDLE;
            pcnt         <= '0;
            tick_pending <= 1'b0;
            tcnt         <= '0;
            acc          <= '0;
            cnt          <= '0;
            osr_q        <= '0;
            adc_start_o  <= 1'b0;
            res_data_o   <= '0;
            res_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
            overrun_o    <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            if (!enable_i || tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + 1'b1;

            // A tick in the same cycle as the START transition keeps the flag set.
            if (tick)
                tick_pending <= 1'b1;
            else if (!enable_i || start_go)
                tick_pending <= 1'b0;

            adc_start_o <= 1'b0;

            if (res_valid_o && res_ready_i)
                res_valid_o <= 1'b0;

            // Set events below override this clear.
            if (clear_i) begin
                overrun_o <= 1'b0;
                timeout_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state  <= WAIT_TICK;
                        busy_o <= 1'b1;
                    end
                end
                WAIT_TICK: begin
                    if (!enable_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        acc    <= '0;
                        cnt    <= '0;
                    end else if (tick_pending) begin
                        state       <= START;
                        adc_start_o <= 1'b1;
                    end
                end
                START: begin
                    tcnt <= '0;
                    if (cnt == '0)
                        osr_q <= osr_clamped;
                    state <= CONVERT;
                end
                CONVERT: begin
                    if (adc_rdy_i) begin
                        if (!enable_i) begin
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            acc   <= acc_sum;
                            cnt   <= cnt_inc;
                            state <= (cnt_inc == group_len) ? DONE : WAIT_TICK;
                        end
                    end else if (tcnt == TO_LAST) begin
                        timeout_o <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= WAIT_TICK;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!res_valid_o || res_ready_i) begin
                        res_data_o  <= average(acc, osr_q);
                        res_valid_o <= 1'b1;
                    end else begin
                        overrun_o <= 1'b1;
                    end
                    acc <= '0;
                    cnt <= '0;
                    if (enable_i) begin
                        state <= WAIT_TICK;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_adc_sequencer.sv
// Directed self-checking bench for sa_adc_sequencer with a fixed-latency SA_ADC model.
module tb_sa_adc_sequencer;

    localparam int DATA_W       = 14;
    localparam int PERIOD_W     = 16;
    localparam int OSR_LOG2_MAX = 4;
    localparam int TIMEOUT      = 1023;

`ifdef SA_ADC_SEQ_ROUND_EN
    localparam logic [DATA_W-1:0] EXP_AVG4  = 14'd102;
    localparam logic [DATA_W-1:0] EXP_AVG16 = 14'd1008;
    localparam logic [DATA_W-1:0] EXP_AVG2  = 14'd16383;
    localparam logic [DATA_W-1:0] EXP_SMALL = 14'd3;
`else
    localparam logic [DATA_W-1:0] EXP_AVG4  = 14'd101;
    localparam logic [DATA_W-1:0] EXP_AVG16 = 14'd1007;
    localparam logic [DATA_W-1:0] EXP_AVG2  = 14'd16382;
    localparam logic [DATA_W-1:0] EXP_SMALL = 14'd2;
`endif

    logic                clk_i;
    logic                reset_ni;
    logic                enable_i;
    logic [PERIOD_W-1:0] period_i;
    logic [2:0]          osr_log2_i;
    logic                clear_i;
    logic                adc_start_o;
    logic [DATA_W-1:0]   adc_data_i;
    logic                adc_rdy_i;
    logic [DATA_W-1:0]   res_data_o;
    logic                res_valid_o;
    logic                res_ready_i;
    logic                busy_o;
    logic                overrun_o;
    logic                timeout_o;

    int tests;
    int fails;

    logic [DATA_W-1:0] samp [0:31];
    int  sidx;
    int  delay_cnt;
    bit  model_on;

    sa_adc_sequencer #(
        .DATA_W      (DATA_W),
        .PERIOD_W    (PERIOD_W),
        .OSR_LOG2_MAX(OSR_LOG2_MAX),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .enable_i   (enable_i),
        .period_i   (period_i),
        .osr_log2_i (osr_log2_i),
        .clear_i    (clear_i),
        .adc_start_o(adc_start_o),
        .adc_data_i (adc_data_i),
        .adc_rdy_i  (adc_rdy_i),
        .res_data_o (res_data_o),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o),
        .timeout_o  (timeout_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // SA_ADC model: result strobe five cycles after each start pulse.
    initial begin
        adc_rdy_i  = 1'b0;
        adc_data_i = '0;
        delay_cnt  = 0;
        forever begin
            @(negedge clk_i);
            adc_rdy_i = 1'b0;
            if (!reset_ni) begin
                delay_cnt = 0;
            end else begin
                if (delay_cnt > 0) begin
                    delay_cnt--;
                    if (delay_cnt == 0) begin
                        adc_rdy_i  = 1'b1;
                        adc_data_i = samp[sidx % 32];
                        sidx++;
                    end
                end
                if (adc_start_o && model_on)
                    delay_cnt = 5;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(negedge clk_i);
        #1;
    endtask

    task automatic go_idle(output bit ok);
        enable_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        sidx = 0;
    endtask

    task automatic collect(output logic [DATA_W-1:0] d, output int nrdy, output bit ok);
        d    = '0;
        nrdy = 0;
        ok   = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (adc_rdy_i) nrdy++;
            if (res_valid_o) begin
                d  = res_data_o;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_ni   = 1'b0;
        enable_i   = 1'b0;
        period_i   = '0;
        osr_log2_i = '0;
        clear_i    = 1'b0;
        res_ready_i = 1'b1;
        model_on   = 1'b1;
        sidx       = 0;
        repeat (3) @(posedge clk_i);
        #1;
        tests++; if (adc_start_o !== 1'b0) begin fails++; $display("FAIL reset_start: got %b want 0", adc_start_o); end
        tests++; if (res_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", res_valid_o); end
        tests++; if (res_data_o !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", res_data_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        tests++; if ({overrun_o, timeout_o} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {overrun_o, timeout_o}); end
        @(negedge clk_i);
        reset_ni = 1'b1;
        repeat (4) step();
        tests++; if ({busy_o, adc_start_o} !== 2'b00) begin fails++; $display("FAIL reset_disabled_idle: got %b want 00", {busy_o, adc_start_o}); end
    endtask

    task automatic test_single;
        int starts[3];
        int ns, n, rdy_n, val_n;
        logic [DATA_W-1:0] d;
        period_i   = 16'd9;
        osr_log2_i = 3'd0;
        res_ready_i = 1'b1;
        for (int i = 0; i < 32; i++) samp[i] = 14'h1234;
        sidx = 0;
        enable_i = 1'b1;
        ns = 0; n = 0; rdy_n = -1; val_n = -1; d = '0;
        while (ns < 3 && n < 200) begin
            step();
            n++;
            if (adc_start_o) begin
                starts[ns] = n;
                ns++;
            end
            if (adc_rdy_i && rdy_n < 0) rdy_n = n;
            if (res_valid_o && val_n < 0) begin
                val_n = n;
                d = res_data_o;
            end
        end
        tests++; if (ns != 3) begin fails++; $display("FAIL single_starts: got %0d starts want 3", ns); end
        tests++; if (starts[0] != 11) begin fails++; $display("FAIL single_first_start: got cycle %0d want 11", starts[0]); end
        tests++; if (starts[1] - starts[0] != 10) begin fails++; $display("FAIL single_period1: got %0d want 10", starts[1] - starts[0]); end
        tests++; if (starts[2] - starts[1] != 10) begin fails++; $display("FAIL single_period2: got %0d want 10", starts[2] - starts[1]); end
        tests++; if (val_n - rdy_n != 2) begin fails++; $display("FAIL single_latency: got %0d want 2", val_n - rdy_n); end
        tests++; if (d !== 14'h1234) begin fails++; $display("FAIL single_data: got %h want 1234", d); end
    endtask

    task automatic test_averaging;
        bit ok;
        int nrdy;
        logic [DATA_W-1:0] d;
        go_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL avg_idle: busy stuck high"); end
        osr_log2_i = 3'd2;
        for (int i = 0; i < 4; i++) samp[i] = 14'(100 + i);
        enable_i = 1'b1;
        collect(d, nrdy, ok);
        tests++; if (!ok || nrdy != 4) begin fails++; $display("FAIL avg4_count: got %0d samples ok=%0d want 4", nrdy, ok); end
        tests++; if (d !== EXP_AVG4) begin fails++; $display("FAIL avg4_data: got %0d want %0d", d, EXP_AVG4); end

        go_idle(ok);
        osr_log2_i = 3'd7;
        for (int i = 0; i < 16; i++) samp[i] = 14'(1000 + i);
        enable_i = 1'b1;
        collect(d, nrdy, ok);
        tests++; if (!ok || nrdy != 16) begin fails++; $display("FAIL avg_clamp_count: got %0d samples ok=%0d want 16", nrdy, ok); end
        tests++; if (d !== EXP_AVG16) begin fails++; $display("FAIL avg_clamp_data: got %0d want %0d", d, EXP_AVG16); end

        go_idle(ok);
        osr_log2_i = 3'd1;
        samp[0] = 14'h3FFF;
        samp[1] = 14'h3FFE;
        enable_i = 1'b1;
        collect(d, nrdy, ok);
        tests++; if (!ok || nrdy != 2 || d !== EXP_AVG2) begin fails++; $display("FAIL avg_fullscale: got %0d (n=%0d) want %0d", d, nrdy, EXP_AVG2); end
    endtask

    task automatic test_backpressure;
        bit ok, got;
        int nrdy;
        logic [DATA_W-1:0] d;
        go_idle(ok);
        osr_log2_i  = 3'd0;
        res_ready_i = 1'b0;
        samp[0] = 14'h0AAA;
        samp[1] = 14'h0BBB;
        samp[2] = 14'h0CCC;
        enable_i = 1'b1;
        collect(d, nrdy, ok);
        tests++; if (!ok || d !== 14'h0AAA) begin fails++; $display("FAIL bp_first: got %h ok=%0d want 0aaa", d, ok); end
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (adc_rdy_i) begin
                got = 1'b1;
                break;
            end
        end
        repeat (3) step();
        tests++; if (!got || overrun_o !== 1'b1) begin fails++; $display("FAIL bp_overrun: got %b want 1", overrun_o); end
        tests++; if (res_valid_o !== 1'b1 || res_data_o !== 14'h0AAA) begin fails++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=0aaa", res_valid_o, res_data_o); end
        clear_i     = 1'b1;
        res_ready_i = 1'b1;
        step();
        clear_i = 1'b0;
        tests++; if ({overrun_o, res_valid_o} !== 2'b00) begin fails++; $display("FAIL bp_clear: got ov=%b v=%b want 0 0", overrun_o, res_valid_o); end
        collect(d, nrdy, ok);
        tests++; if (!ok || d !== 14'h0CCC) begin fails++; $display("FAIL bp_next: got %h want 0ccc", d); end
    endtask

    task automatic test_timeout;
        bit ok, got;
        int n, tfound, nstart, nvalid;
        go_idle(ok);
        model_on    = 1'b0;
        osr_log2_i  = 3'd0;
        res_ready_i = 1'b1;
        enable_i    = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (adc_start_o) begin
                got = 1'b1;
                break;
            end
        end
        tests++; if (!got) begin fails++; $display("FAIL to_start: no start pulse seen"); end
        n = 0; tfound = -1; nstart = -1; nvalid = 0;
        while (nstart < 0 && n < TIMEOUT + 50) begin
            step();
            n++;
            if (res_valid_o) nvalid++;
            if (timeout_o && tfound < 0) tfound = n;
            if (adc_start_o && nstart < 0) nstart = n;
        end
        tests++; if (tfound != TIMEOUT) begin fails++; $display("FAIL to_cycle: got %0d want %0d", tfound, TIMEOUT); end
        tests++; if (nvalid != 0) begin fails++; $display("FAIL to_novalid: got %0d valid cycles want 0", nvalid); end
        tests++; if (nstart < TIMEOUT + 1 || nstart > TIMEOUT + 12) begin fails++; $display("FAIL to_restart: got cycle %0d want %0d..%0d", nstart, TIMEOUT + 1, TIMEOUT + 12); end
        go_idle(ok);
        model_on = 1'b1;
        clear_i  = 1'b1;
        step();
        clear_i = 1'b0;
        tests++; if (!ok || timeout_o !== 1'b0) begin fails++; $display("FAIL to_clear: got %b want 0", timeout_o); end
    endtask

    task automatic test_enable_drop;
        bit ok;
        int ns, nrdy, nvalid, nst;
        logic [DATA_W-1:0] d;
        go_idle(ok);
        osr_log2_i  = 3'd2;
        res_ready_i = 1'b1;
        samp[0] = 14'd10; samp[1] = 14'd20; samp[2] = 14'd30; samp[3] = 14'd40;
        enable_i = 1'b1;
        ns = 0;
        for (int i = 0; i < 100 && ns < 2; i++) begin
            step();
            if (adc_start_o) ns++;
        end
        enable_i = 1'b0;
        step();
        tests++; if (ns != 2 || busy_o !== 1'b1) begin fails++; $display("FAIL drop_inflight: got busy=%b starts=%0d want 1 2", busy_o, ns); end
        nrdy = 0; nvalid = 0; nst = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (adc_rdy_i) nrdy++;
            if (res_valid_o) nvalid++;
            if (adc_start_o) nst++;
        end
        tests++; if (nrdy != 1) begin fails++; $display("FAIL drop_complete: got %0d strobes want 1", nrdy); end
        tests++; if (nvalid != 0 || nst != 0) begin fails++; $display("FAIL drop_quiet: got valid=%0d starts=%0d want 0 0", nvalid, nst); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL drop_idle: got busy=%b want 0", busy_o); end
        sidx = 0;
        samp[0] = 14'd1; samp[1] = 14'd2; samp[2] = 14'd3; samp[3] = 14'd4;
        enable_i = 1'b1;
        collect(d, nrdy, ok);
        tests++; if (!ok || nrdy != 4 || d !== EXP_SMALL) begin fails++; $display("FAIL drop_fresh_group: got %0d (n=%0d) want %0d", d, nrdy, EXP_SMALL); end
    endtask

    task automatic test_async_reset;
        bit ok, got;
        int nrdy, n, first;
        logic [DATA_W-1:0] d;
        go_idle(ok);
        osr_log2_i  = 3'd0;
        res_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) samp[i] = 14'h0777;
        enable_i = 1'b1;
        collect(d, nrdy, ok);
        tests++; if (!ok || d !== 14'h0777) begin fails++; $display("FAIL rst_pre_result: got %h want 0777", d); end
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (adc_start_o) begin
                got = 1'b1;
                break;
            end
        end
        repeat (2) step();
        tests++; if (!got || busy_o !== 1'b1 || res_valid_o !== 1'b1) begin fails++; $display("FAIL rst_pre_state: got busy=%b v=%b want 1 1", busy_o, res_valid_o); end
        #2;
        reset_ni  = 1'b0;
        delay_cnt = 0;
        #1;
        tests++; if ({adc_start_o, res_valid_o, busy_o, overrun_o, timeout_o} !== 5'b0) begin fails++; $display("FAIL rst_async_ctrl: got %b want 00000", {adc_start_o, res_valid_o, busy_o, overrun_o, timeout_o}); end
        tests++; if (res_data_o !== '0) begin fails++; $display("FAIL rst_async_data: got %h want 0", res_data_o); end
        res_ready_i = 1'b1;
        @(negedge clk_i);
        reset_ni = 1'b1;
        n = 0; first = -1;
        while (first < 0 && n < 40) begin
            step();
            n++;
            if (adc_start_o) first = n;
        end
        tests++; if (first != 11) begin fails++; $display("FAIL rst_first_start: got cycle %0d want 11", first); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_averaging();
        test_backpressure();
        test_timeout();
        test_enable_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
